// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and types used by operand_fetch and regfile.
// Also holds the operand-fetch state encoding and the scoreboard query helper.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 16;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } of_state_t;

  // A register still blocks issue if it is busy and is not being written back this cycle.
  function automatic logic still_busy(input logic [NUM_REGS-1:0] busy,
                                      input reg_idx_t            idx,
                                      input logic                wb_valid,
                                      input reg_idx_t            wb_addr);
    return busy[idx] && !(wb_valid && (wb_addr == idx));
  endfunction

endpackage

// File: rtl/scoreboard.sv
// Per-register busy bits for outstanding writes; register 0 is never tracked.
// A set and a clear of the same index in one cycle leaves the bit set.
module scoreboard
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                set_en,
  input  reg_idx_t            set_idx,
  input  logic                clr_en,
  input  reg_idx_t            clr_idx,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:1] busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (set_en && (set_idx == reg_idx_t'(r))) begin
          busy_q[r] <= 1'b1;
        end else if (clr_en && (clr_idx == reg_idx_t'(r))) begin
          busy_q[r] <= 1'b0;
        end
      end
    end
  end

  assign busy = {busy_q, 1'b0};

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: issues regfile reads on accept and presents operands one
// cycle later, stalling any instruction whose sources or destination are still busy.
module operand_fetch
  import cpu_pkg::*;
#(
  parameter int OP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  reg_idx_t          in_a_addr,
  input  reg_idx_t          in_b_addr,
  input  logic              in_use_a,
  input  logic              in_use_b,
  input  reg_idx_t          in_dst_addr,
  input  logic              in_writes,
  input  logic [OP_W-1:0]   in_op,
  output logic              rf_read_a,
  output logic              rf_read_b,
  output reg_idx_t          rf_a_addr,
  output reg_idx_t          rf_b_addr,
  input  logic [DATA_W-1:0] rf_a_out,
  input  logic [DATA_W-1:0] rf_b_out,
  input  logic              wb_valid,
  input  reg_idx_t          wb_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output reg_idx_t          out_dst_addr,
  output logic              out_writes,
  output logic [OP_W-1:0]   out_op
);

  of_state_t           state;
  reg_idx_t            a_addr_q;
  reg_idx_t            b_addr_q;
  logic                use_a_q;
  logic                use_b_q;
  logic [NUM_REGS-1:0] busy;
  logic                hazard;
  logic                fire;
  logic                accept;

  assign hazard = (in_use_a  && still_busy(busy, in_a_addr,   wb_valid, wb_addr)) ||
                  (in_use_b  && still_busy(busy, in_b_addr,   wb_valid, wb_addr)) ||
                  (in_writes && still_busy(busy, in_dst_addr, wb_valid, wb_addr));

  assign out_valid = (state == FULL);
  assign fire      = out_valid && out_ready;
  assign in_ready  = !reset && !hazard && ((state == EMPTY) || fire);
  assign accept    = in_valid && in_ready;

  assign rf_read_a = accept && in_use_a;
  assign rf_read_b = accept && in_use_b;
  assign rf_a_addr = in_a_addr;
  assign rf_b_addr = in_b_addr;

  // The regfile holds its registered read data while we are stalled, so operands pass straight through.
  assign out_a = (out_valid && use_a_q && (a_addr_q != '0)) ? rf_a_out : '0;
  assign out_b = (out_valid && use_b_q && (b_addr_q != '0)) ? rf_b_out : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= EMPTY;
      a_addr_q     <= '0;
      b_addr_q     <= '0;
      use_a_q      <= 1'b0;
      use_b_q      <= 1'b0;
      out_dst_addr <= '0;
      out_writes   <= 1'b0;
      out_op       <= '0;
    end else if (accept) begin
      state        <= FULL;
      a_addr_q     <= in_a_addr;
      b_addr_q     <= in_b_addr;
      use_a_q      <= in_use_a;
      use_b_q      <= in_use_b;
      out_dst_addr <= in_dst_addr;
      out_writes   <= in_writes;
      out_op       <= in_op;
    end else if (fire) begin
      state <= EMPTY;
    end
  end

  scoreboard u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .set_en  (accept && in_writes),
    .set_idx (in_dst_addr),
    .clr_en  (wb_valid),
    .clr_idx (wb_addr),
    .busy    (busy)
  );

endmodule
